ascon_perm_engine: RTL and testbench

ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

---
 rtl/ascon_perm_pkg.sv | 33 +++
 rtl/ascon_sbox_vec.sv | 40 ++++
 rtl/ascon_perm_engine.sv | 193 +++++++++++++++++++
 tb/tb_ascon_perm_engine.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_perm_pkg.sv
// Shared definitions for the ASCON permutation engine: FSM states, linear-layer
// rotation amounts and the round-constant function.
package ascon_perm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONST,
        ST_SBOX,
        ST_LIN,
        ST_UNLOAD
    } state_e;

    localparam int NUM_LANES      = 5;
    localparam int LANE_W         = 64;
    localparam int LAST_ROUND_IDX = 12;

    // Per-lane right-rotation pairs of the linear diffusion layer, x0..x4.
    localparam int ROT_A [NUM_LANES] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [NUM_LANES] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [3:0] hi;
        hi = 4'd15 - idx;
        return {hi, idx};
    endfunction

    function automatic logic [LANE_W-1:0] rotr64(input logic [LANE_W-1:0] x,
                                                 input int unsigned n);
        return (x >> n) | (x << (LANE_W - n));
    endfunction

endpackage

// File: rtl/ascon_sbox_vec.sv
// SLICE_W parallel ASCON 5-bit S-boxes in bit-sliced form; bit b of every lane
// input forms one 5-bit column (x0 is the column MSB).
module ascon_sbox_vec #(
    parameter int SLICE_W = 1
) (
    input  logic [SLICE_W-1:0] x0_i,
    input  logic [SLICE_W-1:0] x1_i,
    input  logic [SLICE_W-1:0] x2_i,
    input  logic [SLICE_W-1:0] x3_i,
    input  logic [SLICE_W-1:0] x4_i,
    output logic [SLICE_W-1:0] x0_o,
    output logic [SLICE_W-1:0] x1_o,
    output logic [SLICE_W-1:0] x2_o,
    output logic [SLICE_W-1:0] x3_o,
    output logic [SLICE_W-1:0] x4_o
);

    logic [SLICE_W-1:0] a0, a1, a2, a3, a4;
    logic [SLICE_W-1:0] b0, b1, b2, b3, b4;

    always_comb begin
        a0 = x0_i ^ x4_i;
        a1 = x1_i;
        a2 = x2_i ^ x1_i;
        a3 = x3_i;
        a4 = x4_i ^ x3_i;
        // Chi-like nonlinear step
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);
        x0_o = b0 ^ b4;
        x1_o = b1 ^ b0;
        x2_o = ~b2;
        x3_o = b3 ^ b2;
        x4_o = b4;
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Serialized ASCON permutation: SLICE_W bits per lane per cycle for load, S-box
// and unload. Optional macro ASCON_PERM_ROUND_CHECK_EN adds an err output.
//   state     | meaning
//   ST_IDLE   | waiting for start, num_rounds captured on start
//   ST_LOAD   | shifting BEATS input slices into the lanes
//   ST_CONST  | XOR round constant into x2[7:0]
//   ST_SBOX   | BEATS cycles of column substitution, MSB slice first
//   ST_LIN    | linear diffusion of all lanes, advance round index
//   ST_UNLOAD | presenting BEATS result slices
module ascon_perm_engine
    import ascon_perm_pkg::*;
#(
    parameter int SLICE_W    = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           num_rounds,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5*SLICE_W-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5*SLICE_W-1:0] data_out,
    output logic                 out_last,
    output logic                 busy
`ifdef ASCON_PERM_ROUND_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int               BEATS     = LANE_W / SLICE_W;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [3:0]       MAX_R     = 4'(MAX_ROUNDS);
    localparam logic [3:0]       END_IDX   = 4'(LAST_ROUND_IDX);

    state_e             state_q;
    logic [LANE_W-1:0]  x_q [NUM_LANES];
    logic [CNT_W-1:0]   beat_q;
    logic [3:0]         rnd_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               busy_q;

    logic               beat_last;
    logic [CNT_W-1:0]   beat_d;
    logic [3:0]         rnd_d;
    logic               rounds_bad;
    logic               start_ok;
    logic [3:0]         rnd_init;

    logic [SLICE_W-1:0] top_s  [NUM_LANES];
    logic [SLICE_W-1:0] din_s  [NUM_LANES];
    logic [SLICE_W-1:0] sbox_s [NUM_LANES];
    logic [LANE_W-1:0]  load_d [NUM_LANES];
    logic [LANE_W-1:0]  sbox_d [NUM_LANES];
    logic [LANE_W-1:0]  lin_d  [NUM_LANES];
    logic [LANE_W-1:0]  shl_d  [NUM_LANES];

    always_comb begin
        beat_last  = (beat_q == LAST_BEAT);
        beat_d     = beat_last ? '0 : beat_q + 1'b1;
        rnd_d      = rnd_q + 4'd1;
        rounds_bad = (num_rounds == 4'd0) || (num_rounds > MAX_R);
    end

`ifdef ASCON_PERM_ROUND_CHECK_EN
    logic err_q;
    assign start_ok = start && !rounds_bad;
    assign rnd_init = END_IDX - num_rounds;
    assign err      = err_q;
`else
    localparam logic [3:0] CLAMP_IDX = 4'(LAST_ROUND_IDX - MAX_ROUNDS);
    assign start_ok = start;
    assign rnd_init = rounds_bad ? CLAMP_IDX : END_IDX - num_rounds;
`endif

    // Every serial phase shifts lanes left by one slice: after BEATS shifts the
    // slice order is restored, so load, substitution and unload share one path.
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        assign top_s[j]  = x_q[j][LANE_W-1 -: SLICE_W];
        assign din_s[j]  = data_in[(NUM_LANES-j)*SLICE_W-1 -: SLICE_W];
        assign shl_d[j]  = x_q[j] << SLICE_W;
        assign load_d[j] = shl_d[j] | LANE_W'(din_s[j]);
        assign sbox_d[j] = shl_d[j] | LANE_W'(sbox_s[j]);
        assign lin_d[j]  = x_q[j] ^ rotr64(x_q[j], ROT_A[j]) ^ rotr64(x_q[j], ROT_B[j]);
    end

    ascon_sbox_vec #(
        .SLICE_W (SLICE_W)
    ) u_sbox (
        .x0_i (top_s[0]),
        .x1_i (top_s[1]),
        .x2_i (top_s[2]),
        .x3_i (top_s[3]),
        .x4_i (top_s[4]),
        .x0_o (sbox_s[0]),
        .x1_o (sbox_s[1]),
        .x2_o (sbox_s[2]),
        .x3_o (sbox_s[3]),
        .x4_o (sbox_s[4])
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            for (int j = 0; j < NUM_LANES; j++) x_q[j] <= '0;
            beat_q      <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ASCON_PERM_ROUND_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef ASCON_PERM_ROUND_CHECK_EN
            err_q <= (state_q == ST_IDLE) && start && rounds_bad;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q    <= ST_LOAD;
                        rnd_q      <= rnd_init;
                        beat_q     <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        for (int j = 0; j < NUM_LANES; j++) x_q[j] <= load_d[j];
                        beat_q <= beat_d;
                        if (beat_last) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_CONST;
                        end
                    end
                end
                ST_CONST: begin
                    x_q[2]  <= x_q[2] ^ {56'd0, round_const(rnd_q)};
                    state_q <= ST_SBOX;
                end
                ST_SBOX: begin
                    for (int j = 0; j < NUM_LANES; j++) x_q[j] <= sbox_d[j];
                    beat_q <= beat_d;
                    if (beat_last) state_q <= ST_LIN;
                end
                ST_LIN: begin
                    for (int j = 0; j < NUM_LANES; j++) x_q[j] <= lin_d[j];
                    rnd_q <= rnd_d;
                    if (rnd_d < END_IDX) begin
                        state_q <= ST_CONST;
                    end else begin
                        state_q     <= ST_UNLOAD;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (LAST_BEAT == '0);
                    end
                end
                ST_UNLOAD: begin
                    if (out_valid_q && out_ready) begin
                        for (int j = 0; j < NUM_LANES; j++) x_q[j] <= shl_d[j];
                        beat_q     <= beat_d;
                        out_last_q <= (beat_d == LAST_BEAT);
                        if (beat_last) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            rnd_q       <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign data_out  = out_valid_q ? {top_s[0], top_s[1], top_s[2], top_s[3], top_s[4]}
                                   : '0;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine (SLICE_W=8) against a column/table
// based ASCON permutation model.
module tb_ascon_perm_engine;

    localparam int SW    = 8;
    localparam int BEATS = 64 / SW;
    localparam int DW    = 5 * SW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    num_rounds;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          out_last;
    logic          busy;
`ifdef ASCON_PERM_ROUND_CHECK_EN
    logic          err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [4:0] sbox_t [32];

    ascon_perm_engine #(
        .SLICE_W    (SW),
        .MAX_ROUNDS (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rounds (num_rounds),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_last   (out_last),
        .busy       (busy)
`ifdef ASCON_PERM_ROUND_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string name, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int a);
        logic [63:0] x [5];
        logic [4:0]  col;
        for (int j = 0; j < 5; j++) x[j] = s[319-64*j -: 64];
        for (int r = 12 - a; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                col = sbox_t[col];
                x[0][b] = col[4];
                x[1][b] = col[3];
                x[2][b] = col[2];
                x[3][b] = col[1];
                x[4][b] = col[0];
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int eff_rounds(input int a);
        return (a == 0 || a > 12) ? 12 : a;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] slice_of(input logic [319:0] s, input int k);
        logic [DW-1:0] d;
        for (int j = 0; j < 5; j++) d[(5-j)*SW-1 -: SW] = s[319-64*j-SW*k -: SW];
        return d;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic load_state(input logic [319:0] s, input int gaps);
        int   k = 0;
        int   guard = 0;
        logic rdy;
        while (k < BEATS && guard < 1000) begin
            in_valid = (gaps != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in  = in_valid ? slice_of(s, k) : DW'({$urandom(), $urandom()});
            rdy      = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk_int("load_beats", k, BEATS);
    endtask

    task automatic unload(input int stall, input bit poke, output logic [319:0] res);
        int            k = 0;
        int            guard = 0;
        int            cyc = 0;
        logic [DW-1:0] d;
        logic          l, v, r;
        bit            stable_ok = 1'b1;
        bit            last_ok = 1'b1;
        res = '0;
        while (k < BEATS && guard < 2000) begin
            case (stall)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (poke) begin
                in_valid = 1'b1;
                data_in  = DW'({$urandom(), $urandom()});
            end
            d = data_out;
            l = out_last;
            v = out_valid;
            @(posedge clk); #1;
            cyc++;
            guard++;
            if (v && r) begin
                for (int j = 0; j < 5; j++) res[319-64*j-SW*k -: SW] = d[(5-j)*SW-1 -: SW];
                if (l !== (k == BEATS - 1)) last_ok = 1'b0;
                k++;
            end else if (v) begin
                if (data_out !== d || out_last !== l) stable_ok = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_int("unload_beats", k, BEATS);
        chk_bit("unload_last_only_final", last_ok, 1'b1);
        chk_bit("unload_stable_stall", stable_ok, 1'b1);
        chk_bit("unload_valid_drop", out_valid, 1'b0);
        chk_bit("unload_busy_drop", busy, 1'b0);
    endtask

    task automatic run_call(input logic [319:0] st, input logic [3:0] a, input int gaps,
                            input int stall, input bit poke,
                            output logic [319:0] res, output int lat);
        bit busy_ok = 1'b1;
        start      = 1'b1;
        num_rounds = a;
        @(posedge clk); #1;
        start      = 1'b0;
        chk_bit("busy_after_start", busy, 1'b1);
        load_state(st, gaps);
        lat = 0;
        while (!out_valid && lat < 4000) begin
            if (poke && lat == 3) begin
                start      = 1'b1;
                num_rounds = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (!out_valid && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk_bit("busy_during_rounds", busy_ok, 1'b1);
        unload(stall, poke, res);
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [319:0] st;
        logic [3:0]   a;
        int           gaps;
        int           stall;
        logic [319:0] exp;
        int           lat;
    } vec_t;

    vec_t         vt [7];
    logic [319:0] res;
    logic [319:0] st;
    int           lat;
    int           ra;
    bit           quiet;

    initial begin
        sbox_t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                   5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                   5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                   5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

        rst = 1'b0; start = 1'b0; num_rounds = '0;
        in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_last", out_last, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_val("rst_data_out", 320'(data_out), '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_bit("idle_busy", busy, 1'b0);

        vt[0] = '{st: '0, a: 4'd12, gaps: 0, stall: 0, exp: '0, lat: 0};
        vt[1] = '{st: {64'h0123456789ABCDEF, 64'h123456789ABCDEF0, 64'h23456789ABCDEF01,
                       64'h3456789ABCDEF012, 64'h456789ABCDEF0123},
                  a: 4'd6, gaps: 0, stall: 0, exp: '0, lat: 0};
        vt[2] = '{st: {5{64'hFFFF_FFFF_FFFF_FFFF}}, a: 4'd1, gaps: 1, stall: 1, exp: '0, lat: 0};
        vt[3] = '{st: rand320(), a: 4'd8, gaps: 1, stall: 2, exp: '0, lat: 0};
        vt[4] = '{st: vt[1].st, a: 4'd6, gaps: 0, stall: 1, exp: '0, lat: 0};
        vt[5] = '{st: rand320(), a: 4'd13, gaps: 0, stall: 0, exp: '0, lat: 0};
        vt[6] = '{st: rand320(), a: 4'd0, gaps: 1, stall: 0, exp: '0, lat: 0};
        for (int i = 0; i < 7; i++) begin
            vt[i].exp = ref_perm(vt[i].st, eff_rounds(int'(vt[i].a)));
            vt[i].lat = eff_rounds(int'(vt[i].a)) * (BEATS + 2);
        end

        for (int i = 0; i < 7; i++) begin
`ifdef ASCON_PERM_ROUND_CHECK_EN
            if (vt[i].a == 4'd0 || vt[i].a > 4'd12) continue;
`endif
            run_call(vt[i].st, vt[i].a, vt[i].gaps, vt[i].stall, 1'b0, res, lat);
            chk_val($sformatf("vec%0d_result", i), res, vt[i].exp);
            chk_int($sformatf("vec%0d_latency", i), lat, vt[i].lat);
        end

        for (int i = 0; i < 6; i++) begin
            st = rand320();
            ra = $urandom_range(1, 12);
            run_call(st, 4'(ra), 1, 2, 1'b0, res, lat);
            chk_val($sformatf("rand%0d_result", i), res, ref_perm(st, ra));
            chk_int($sformatf("rand%0d_latency", i), lat, ra * (BEATS + 2));
        end

        st = rand320();
        run_call(st, 4'd4, 0, 0, 1'b1, res, lat);
        chk_val("poke_result", res, ref_perm(st, 4));
        chk_int("poke_latency", lat, 4 * (BEATS + 2));
        @(posedge clk); #1;
        chk_bit("poke_idle_after", busy, 1'b0);

        // Reset asserted in the middle of a round aborts the call.
        st = rand320();
        start = 1'b1; num_rounds = 4'd12;
        @(posedge clk); #1;
        start = 1'b0;
        load_state(st, 0);
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) quiet = 1'b0;
        end
        chk_bit("midrst_no_partial_output", quiet, 1'b1);
        run_call(st, 4'd12, 0, 0, 1'b0, res, lat);
        chk_val("midrst_rerun_result", res, ref_perm(st, 12));

`ifdef ASCON_PERM_ROUND_CHECK_EN
        start = 1'b1; num_rounds = 4'd13;
        @(posedge clk); #1;
        start = 1'b0;
        chk_bit("bad_rounds_err_pulse", err, 1'b1);
        chk_bit("bad_rounds_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk_bit("bad_rounds_err_clear", err, 1'b0);
        chk_bit("bad_rounds_still_idle", busy, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
